// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: walks one full_adder cell across WIDTH bits LSB-first,
// with a registered carry, and holds the finished sum/carry on output registers.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   r_sr_q, r_sr_d;
  logic               cy_q, cy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_out_q, sum_out_d;
  logic               cout_q, cout_d;

  logic               fa_sum, fa_carry;
  logic [WIDTH:0]     r_cat;
  logic [WIDTH-1:0]   r_next;

  full_adder u_fa (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .c  (cy_q),
    .s  (fa_sum),
    .co (fa_carry)
  );

  // New bit enters at the MSB; building it this way stays legal when WIDTH is 1.
  assign r_cat  = {fa_sum, r_sr_q};
  assign r_next = r_cat[WIDTH:1];

  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    r_sr_d    = r_sr_q;
    cy_d      = cy_q;
    cnt_d     = cnt_q;
    sum_out_d = sum_out_q;
    cout_d    = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a_in;
          b_sr_d  = b_in;
          cy_d    = cin;
          cnt_d   = '0;
          r_sr_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        r_sr_d = r_next;
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        cy_d   = fa_carry;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_out_d = r_next;
          cout_d    = fa_carry;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      r_sr_q    <= '0;
      cy_q      <= 1'b0;
      cnt_q     <= '0;
      sum_out_q <= '0;
      cout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      r_sr_q    <= r_sr_d;
      cy_q      <= cy_d;
      cnt_q     <= cnt_d;
      sum_out_q <= sum_out_d;
      cout_q    <= cout_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign sum_out = sum_out_q;
  assign cout    = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8): vector table plus hand-written
// sequences for reset, ignored requests and back-to-back operation.

module tb_serial_add_ctrl;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a_in, b_in;
  logic             cin;
  logic             busy, done, cout;
  logic [WIDTH-1:0] sum_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t vecs[8];

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .sum_out (sum_out),
    .cout    (cout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Presents operands with start for exactly one edge; returns 1 ns after the accept edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    cin   = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = 8'($urandom);
    b_in  = 8'($urandom);
    cin   = 1'b0;
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Counts edges until done is seen; tracks that sum_out holds and busy stays high meanwhile.
  task automatic waitDone(input logic [7:0] hold_val, output int n, output bit held, output bit busy_ok);
    n       = 0;
    held    = 1'b1;
    busy_ok = 1'b1;
    while (1) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
      if (sum_out !== hold_val) held = 1'b0;
      if (n >= 2 && !busy) busy_ok = 1'b0;
      if (n >= 40) begin
        n = -1;
        break;
      end
    end
  endtask

  initial begin
    int         n, dones;
    bit         held, bok;
    logic [7:0] prev_sum, cap_sum;
    vec_t       b2b[3];

    vecs[0] = '{a: 8'h0F, b: 8'h01, c: 1'b0, s: 8'h10, co: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, c: 1'b0, s: 8'h00, co: 1'b1};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, c: 1'b1, s: 8'hFF, co: 1'b1};
    vecs[3] = '{a: 8'h00, b: 8'h00, c: 1'b1, s: 8'h01, co: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h80, c: 1'b0, s: 8'h00, co: 1'b1};
    vecs[5] = '{a: 8'h12, b: 8'h34, c: 1'b1, s: 8'h47, co: 1'b0};
    vecs[6] = '{a: 8'hAA, b: 8'h55, c: 1'b0, s: 8'hFF, co: 1'b0};
    vecs[7] = '{a: 8'h7F, b: 8'h01, c: 1'b0, s: 8'h80, co: 1'b0};

    b2b[0] = '{a: 8'h01, b: 8'h02, c: 1'b0, s: 8'h03, co: 1'b0};
    b2b[1] = '{a: 8'hF0, b: 8'h20, c: 1'b1, s: 8'h11, co: 1'b1};
    b2b[2] = '{a: 8'h7F, b: 8'h80, c: 1'b1, s: 8'h00, co: 1'b1};

    // Reset from time zero with start asserted; outputs must be cleared before any edge.
    rst_n = 1'b0;
    start = 1'b1;
    a_in  = 8'hC3;
    b_in  = 8'h3C;
    cin   = 1'b1;
    #3;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_sum", 32'(sum_out), 32'd0);
    checkOutput("rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_rst_busy", 32'(busy), 32'd0);
    checkOutput("post_rst_sum", 32'(sum_out), 32'd0);

    prev_sum = 8'h00;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].c);
      waitDone(prev_sum, n, held, bok);
      checkOutput($sformatf("vec%0d_latency", i), 32'(n), 32'd8);
      checkOutput($sformatf("vec%0d_sum", i), 32'(sum_out), 32'(vecs[i].s));
      checkOutput($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].co));
      checkOutput($sformatf("vec%0d_hold", i), 32'(held), 32'd1);
      checkOutput($sformatf("vec%0d_busy_run", i), 32'(bok), 32'd1);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
      checkOutput($sformatf("vec%0d_busy_idle", i), 32'(busy), 32'd0);
      prev_sum = vecs[i].s;
    end

    // A second request three cycles into a run is dropped, not queued.
    applyStimulus(8'h5A, 8'h33, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    a_in  = 8'h11;
    b_in  = 8'h11;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dones   = 0;
    cap_sum = 8'h00;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        dones++;
        cap_sum = sum_out;
      end
    end
    checkOutput("ignore_done_count", 32'(dones), 32'd1);
    checkOutput("ignore_sum", 32'(cap_sum), 32'h8D);
    checkOutput("ignore_cout", 32'(cout), 32'd0);
    checkOutput("ignore_idle", 32'(busy), 32'd0);

    // Reset in the middle of a run aborts it and clears the result registers.
    applyStimulus(8'hA5, 8'h5A, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrun_rst_busy", 32'(busy), 32'd0);
    checkOutput("midrun_rst_done", 32'(done), 32'd0);
    checkOutput("midrun_rst_sum", 32'(sum_out), 32'd0);
    checkOutput("midrun_rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    checkOutput("midrun_no_done", 32'(dones), 32'd0);
    checkOutput("midrun_sum_cleared", 32'(sum_out), 32'd0);
    applyStimulus(8'h01, 8'h02, 1'b0);
    waitDone(8'h00, n, held, bok);
    checkOutput("after_rst_latency", 32'(n), 32'd8);
    checkOutput("after_rst_sum", 32'(sum_out), 32'h03);
    checkOutput("after_rst_hold", 32'(held), 32'd1);

    // start held high: accepts every WIDTH+2 edges, each with fresh operands.
    @(posedge clk);
    #1;
    prev_sum = 8'h03;
    @(negedge clk);
    a_in  = b2b[0].a;
    b_in  = b2b[0].b;
    cin   = b2b[0].c;
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      waitDone(prev_sum, n, held, bok);
      checkOutput($sformatf("b2b%0d_spacing", k), 32'(n), (k == 0) ? 32'd9 : 32'd10);
      checkOutput($sformatf("b2b%0d_sum", k), 32'(sum_out), 32'(b2b[k].s));
      checkOutput($sformatf("b2b%0d_cout", k), 32'(cout), 32'(b2b[k].co));
      checkOutput($sformatf("b2b%0d_hold", k), 32'(held), 32'd1);
      if (k < 2) begin
        a_in = b2b[k+1].a;
        b_in = b2b[k+1].b;
        cin  = b2b[k+1].c;
      end else begin
        start = 1'b0;
      end
      prev_sum = b2b[k].s;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("b2b_final_idle", 32'(busy), 32'd0);
    checkOutput("b2b_final_sum", 32'(sum_out), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
